// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of a single-port memory slave: grants one access at a time,
// waits MEM_LATENCY cycles for the slave, then pulses a one-cycle ack to the owner.
module mem_bus_arbiter #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter bit          FIXED_PRIO  = 1'b0
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iM0Req,
    input  logic        iM0Write,
    input  logic [3:0]  iM0ByteEnable,
    input  logic [31:0] iM0Address,
    input  logic [31:0] iM0WriteData,
    output logic [31:0] oM0ReadData,
    output logic        oM0Ack,
    output logic        oM0Stall,
    input  logic        iM1Req,
    input  logic        iM1Write,
    input  logic [3:0]  iM1ByteEnable,
    input  logic [31:0] iM1Address,
    input  logic [31:0] iM1WriteData,
    output logic [31:0] oM1ReadData,
    output logic        oM1Ack,
    output logic        oSReadEnable,
    output logic        oSWriteEnable,
    output logic [3:0]  oSByteEnable,
    output logic [31:0] oSAddress,
    output logic [31:0] oSWriteData,
    input  logic [31:0] iSReadData,
    output logic        oBusy,
    output logic        oOwner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESPOND
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        first_q, first_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic        wr_q, wr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic any_req;
    logic winner;

    assign any_req = iM0Req | iM1Req;
    // On a tie the master that did not win last time goes next, unless M0 has fixed priority.
    assign winner  = (iM0Req & iM1Req) ? (FIXED_PRIO ? 1'b0 : ~last_owner_q) : iM1Req;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        first_d      = first_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wr_d         = wr_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d      = S_ACCESS;
                    cnt_d        = CNT_INIT;
                    first_d      = 1'b1;
                    owner_d      = winner;
                    last_owner_d = winner;
                    wr_d         = winner ? iM1Write      : iM0Write;
                    be_d         = winner ? iM1ByteEnable : iM0ByteEnable;
                    addr_d       = winner ? iM1Address    : iM0Address;
                    wdata_d      = winner ? iM1WriteData  : iM0WriteData;
                end
            end
            S_ACCESS: begin
                first_d = 1'b0;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESPOND;
                    if (!wr_q) begin
                        if (owner_q) rdata1_d = iSReadData;
                        else         rdata0_d = iSReadData;
                    end
                end
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (iRST) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            first_q      <= 1'b0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            wr_q         <= 1'b0;
            be_q         <= 4'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            wr_q         <= wr_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign oSReadEnable  = (state_q == S_ACCESS) & ~wr_q;
    // Strobe the write only once per transaction even when the slave is slow.
    assign oSWriteEnable = (state_q == S_ACCESS) & wr_q & first_q;
    assign oSByteEnable  = be_q;
    assign oSAddress     = addr_q;
    assign oSWriteData   = wdata_q;
    assign oM0Ack        = (state_q == S_RESPOND) & ~owner_q;
    assign oM1Ack        = (state_q == S_RESPOND) &  owner_q;
    assign oM0Stall      = iM0Req & ~oM0Ack;
    assign oM0ReadData   = rdata0_q;
    assign oM1ReadData   = rdata1_q;
    assign oBusy         = (state_q != S_IDLE);
    assign oOwner        = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Drives three arbiter configurations (latency 1 round-robin, latency 4 round-robin,
// latency 1 fixed priority) and compares them to a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int NH      = 3;
    localparam int MAX_CYC = 4096;

    typedef struct {
        int          m;
        bit          wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          g;
    } txn_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic        rst    [NH];
    logic [1:0]  req    [NH];
    logic [1:0]  wr     [NH];
    logic [3:0]  be     [NH][2];
    logic [31:0] addr   [NH][2];
    logic [31:0] wdata  [NH][2];
    logic [31:0] sdata_in;
    logic [31:0] rd0    [NH];
    logic [31:0] rd1    [NH];
    logic [31:0] saddr  [NH];
    logic [31:0] swdata [NH];
    logic [3:0]  sbe    [NH];
    logic        ack0   [NH];
    logic        ack1   [NH];
    logic        stall0 [NH];
    logic        sre    [NH];
    logic        swe    [NH];
    logic        busy   [NH];
    logic        owner  [NH];

    logic [31:0] sdata [MAX_CYC];
    bit          finishing  = 1'b0;
    bit          final_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NH; g++) begin : g_dut
        mem_bus_arbiter #(
            .MEM_LATENCY (g == 1 ? 4 : 1),
            .FIXED_PRIO  (g == 2)
        ) u_dut (
            .iCLK          (clk),
            .iRST          (rst[g]),
            .iM0Req        (req[g][0]),
            .iM0Write      (wr[g][0]),
            .iM0ByteEnable (be[g][0]),
            .iM0Address    (addr[g][0]),
            .iM0WriteData  (wdata[g][0]),
            .oM0ReadData   (rd0[g]),
            .oM0Ack        (ack0[g]),
            .oM0Stall      (stall0[g]),
            .iM1Req        (req[g][1]),
            .iM1Write      (wr[g][1]),
            .iM1ByteEnable (be[g][1]),
            .iM1Address    (addr[g][1]),
            .iM1WriteData  (wdata[g][1]),
            .oM1ReadData   (rd1[g]),
            .oM1Ack        (ack1[g]),
            .oSReadEnable  (sre[g]),
            .oSWriteEnable (swe[g]),
            .oSByteEnable  (sbe[g]),
            .oSAddress     (saddr[g]),
            .oSWriteData   (swdata[g]),
            .iSReadData    (sdata_in),
            .oBusy         (busy[g]),
            .oOwner        (owner[g])
        );
    end

    function automatic int lat_of(input int h);
        return (h == 1) ? 4 : 1;
    endfunction

    function automatic bit fp_of(input int h);
        return (h == 2);
    endfunction

    task automatic check(input string name, input int h, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, h, cyc, act, exp);
        end
    endtask

    // ---------------- reference model and scoreboard ----------------
    txn_t        scb        [NH][$];
    txn_t        cur        [NH];
    int          free_at    [NH];
    bit          last_owner [NH];
    bit          owner_e    [NH];
    logic [31:0] rd_e       [NH][2];
    int          n_acks     [NH];

    task automatic model_reset(input int h, input int k);
        scb[h].delete();
        cur[h]        = '{m: 0, wr: 1'b0, be: 4'h0, addr: 32'h0, wdata: 32'h0, rdata: 32'h0, g: -100};
        owner_e[h]    = 1'b0;
        last_owner[h] = 1'b1;
        rd_e[h][0]    = 32'h0;
        rd_e[h][1]    = 32'h0;
        free_at[h]    = k + 2;
    endtask

    task automatic monitor_cycle(input int h);
        int   lat;
        int   m;
        bit   in_acc;
        bit   e_ack0;
        bit   e_ack1;
        txn_t t;
        lat    = lat_of(h);
        in_acc = (cyc >= cur[h].g) && (cyc <= cur[h].g + lat - 1);
        e_ack0 = (cyc == cur[h].g + lat) && (cur[h].m == 0);
        e_ack1 = (cyc == cur[h].g + lat) && (cur[h].m == 1);

        check("busy",    h, 32'(busy[h]),   32'(in_acc || e_ack0 || e_ack1));
        check("owner",   h, 32'(owner[h]),  32'(owner_e[h]));
        check("s_rd_en", h, 32'(sre[h]),    32'(in_acc && !cur[h].wr));
        check("s_wr_en", h, 32'(swe[h]),    32'((cyc == cur[h].g) && cur[h].wr));
        check("s_addr",  h, saddr[h],       cur[h].addr);
        check("s_be",    h, 32'(sbe[h]),    32'(cur[h].be));
        check("s_wdata", h, swdata[h],      cur[h].wdata);
        check("ack0",    h, 32'(ack0[h]),   32'(e_ack0));
        check("ack1",    h, 32'(ack1[h]),   32'(e_ack1));
        check("stall0",  h, 32'(stall0[h]), 32'(req[h][0] && !e_ack0));

        if (ack0[h] === 1'b1 || ack1[h] === 1'b1) begin
            n_acks[h]++;
            check("ack_has_txn", h, 32'(scb[h].size() > 0), 32'd1);
            if (scb[h].size() > 0) begin
                t = scb[h].pop_front();
                check("ack_master", h, 32'(ack1[h]), 32'(t.m));
                check("ack_cycle",  h, cyc, t.g + lat);
                if (!t.wr) rd_e[h][t.m] = t.rdata;
            end
        end
        check("rdata0", h, rd0[h], rd_e[h][0]);
        check("rdata1", h, rd1[h], rd_e[h][1]);

        // Decide what the upcoming clock edge does from the inputs now stable.
        if (rst[h]) begin
            model_reset(h, cyc);
        end else if (cyc + 1 >= free_at[h] && req[h] != 2'b00) begin
            if (req[h] == 2'b11) m = fp_of(h) ? 0 : (last_owner[h] ? 0 : 1);
            else                 m = req[h][1] ? 1 : 0;
            t.m     = m;
            t.wr    = wr[h][m];
            t.be    = be[h][m];
            t.addr  = addr[h][m];
            t.wdata = wdata[h][m];
            t.g     = cyc + 1;
            t.rdata = sdata[cyc + lat];
            scb[h].push_back(t);
            cur[h]        = t;
            owner_e[h]    = (m == 1);
            last_owner[h] = (m == 1);
            free_at[h]    = t.g + lat + 2;
        end
    endtask

    initial begin
        for (int h = 0; h < NH; h++) begin
            model_reset(h, 0);
            n_acks[h] = 0;
        end
        forever begin
            @(negedge clk);
            for (int h = 0; h < NH; h++) monitor_cycle(h);
            if (finishing && !final_done) begin
                for (int h = 0; h < NH; h++) begin
                    check("scb_drained",  h, 32'(scb[h].size()), 32'd0);
                    check("txn_activity", h, 32'(n_acks[h] > 20), 32'd1);
                end
                final_done = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic rand_fields(input int h, input int m);
        wr[h][m]    = 1'($urandom_range(0, 1));
        be[h][m]    = 4'($urandom);
        addr[h][m]  = $urandom;
        wdata[h][m] = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        sdata_in = sdata[cyc];
    endtask

    function automatic bit ack_of(input int h, input int m);
        return (m == 0) ? ack0[h] : ack1[h];
    endfunction

    task automatic drive_random(input int h, input int m);
        if (req[h][m]) begin
            if (ack_of(h, m)) begin
                if ($urandom_range(0, 1) == 1) rand_fields(h, m);
                else                           req[h][m] = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                req[h][m] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                rand_fields(h, m);
            end
        end else if ($urandom_range(0, 2) == 0) begin
            req[h][m] = 1'b1;
            rand_fields(h, m);
        end
    endtask

    initial begin
        for (int i = 0; i < MAX_CYC; i++) sdata[i] = $urandom;
        sdata_in = sdata[0];
        for (int h = 0; h < NH; h++) begin
            rst[h] = 1'b1;
            req[h] = 2'b00;
            wr[h]  = 2'b00;
            for (int m = 0; m < 2; m++) begin
                be[h][m]    = 4'h0;
                addr[h][m]  = 32'h0;
                wdata[h][m] = 32'h0;
            end
        end
        repeat (2) step();
        for (int h = 0; h < NH; h++) rst[h] = 1'b0;

        // Both masters requesting continuously: exercises the tie-break rule.
        for (int h = 0; h < NH; h++) begin
            req[h] = 2'b11;
            rand_fields(h, 0);
            rand_fields(h, 1);
        end
        repeat (40) begin
            step();
            for (int h = 0; h < NH; h++)
                for (int m = 0; m < 2; m++)
                    if (ack_of(h, m)) rand_fields(h, m);
        end

        repeat (600) begin
            step();
            for (int h = 0; h < NH; h++)
                for (int m = 0; m < 2; m++) drive_random(h, m);
        end

        // Reset in the middle of an M1 read, then carry on.
        for (int h = 0; h < NH; h++) req[h] = 2'b00;
        repeat (8) step();
        for (int h = 0; h < NH; h++) begin
            rand_fields(h, 1);
            wr[h][1]  = 1'b0;
            req[h][1] = 1'b1;
        end
        for (int k = 1; k <= 2; k++) begin
            step();
            for (int h = 0; h < NH; h++) begin
                if (k == ((lat_of(h) >= 2) ? 2 : 1)) begin
                    rst[h]    = 1'b1;
                    req[h][1] = 1'b0;
                end else begin
                    rst[h] = 1'b0;
                end
            end
        end
        step();
        for (int h = 0; h < NH; h++) rst[h] = 1'b0;

        repeat (300) begin
            step();
            for (int h = 0; h < NH; h++)
                for (int m = 0; m < 2; m++) drive_random(h, m);
        end

        for (int h = 0; h < NH; h++) req[h] = 2'b00;
        repeat (10) step();
        finishing = 1'b1;
        for (int i = 0; i < 4 && !final_done; i++) @(negedge clk);
        #1;
        if (!final_done) begin
            n_checks++;
            n_errors++;
            $display("FAIL final_checks not reached got=0 want=1");
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
